joy_db15_tx: RTL and testbench



---
 rtl/joy_db15_tx.sv | 112 +++++++++++
 tb/tb_joy_db15_tx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/joy_db15_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | joy_db15_tx : two-player joystick state to DB15 serial frame transmitter    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module joy_db15_tx #(
   parameter int BITS    = 24,
   parameter int SYNC    = 2,
   parameter int TIMEOUT = 2000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [11:0] joy1,
   input  logic [11:0] joy2,
   input  logic        joy_load_i,
   input  logic        joy_clk_i,
   output logic        joy_data_o,
   output logic        frame_done,
   output logic        active,
   output logic [5:0]  bit_cnt
);
   localparam int                c_WD_W    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [c_WD_W-1:0] c_TIMEOUT = c_WD_W'(TIMEOUT);
   localparam logic [5:0]        c_BITS    = 6'(BITS);
   localparam logic [5:0]        c_LAST    = 6'(BITS - 1);

   logic [SYNC-1:0]   r_ld_sync;
   logic [SYNC-1:0]   r_ck_sync;
   logic              r_ld_prev;
   logic              r_ck_prev;
   logic [BITS-1:0]   r_sr;
   logic [5:0]        r_bit_cnt;
   logic              r_data;
   logic              r_frame_done;
   logic [c_WD_W-1:0] r_wd;

   logic [23:0]       w_raw;
   logic [BITS-1:0]   w_frame;
   logic              w_ld_s;
   logic              w_ck_s;
   logic              w_ck_rise;
   logic              w_ld_fall;

   assign w_raw     = ~{joy2, joy1};
   assign w_ld_s    = r_ld_sync[SYNC-1];
   assign w_ck_s    = r_ck_sync[SYNC-1];
   assign w_ck_rise = w_ck_s & ~r_ck_prev;
   assign w_ld_fall = ~w_ld_s & r_ld_prev;

   // Frames longer than the 24 button bits are padded with released (1) bits on top
   generate
      if (BITS <= 24) begin : g_trunc
         assign w_frame = w_raw[BITS-1:0];
      end else begin : g_pad
         assign w_frame = {{(BITS-24){1'b1}}, w_raw};
      end
   endgenerate

   // Edge-history flops reset to the idle levels so release cannot fake an edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ld_sync <= '1;
         r_ck_sync <= '0;
         r_ld_prev <= 1'b1;
         r_ck_prev <= 1'b0;
      end else begin
         r_ld_sync <= {r_ld_sync[SYNC-2:0], joy_load_i};
         r_ck_sync <= {r_ck_sync[SYNC-2:0], joy_clk_i};
         r_ld_prev <= w_ld_s;
         r_ck_prev <= w_ck_s;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sr         <= '1;
         r_bit_cnt    <= '0;
         r_data       <= 1'b1;
         r_frame_done <= 1'b0;
      end else begin
         r_data       <= r_sr[BITS-1];
         r_frame_done <= 1'b0;
         if (!w_ld_s) begin
            r_sr      <= w_frame;
            r_bit_cnt <= '0;
         end else if (w_ck_rise) begin
            r_sr <= {r_sr[BITS-2:0], 1'b1};
            if (r_bit_cnt != c_BITS) begin
               r_bit_cnt <= r_bit_cnt + 6'd1;
            end
            r_frame_done <= (r_bit_cnt == c_LAST);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wd <= '0;
      end else if (w_ld_fall) begin
         r_wd <= c_TIMEOUT;
      end else if (r_wd != '0) begin
         r_wd <= r_wd - 1'b1;
      end
   end

   assign joy_data_o = r_data;
   assign frame_done = r_frame_done;
   assign bit_cnt    = r_bit_cnt;
   assign active     = (r_wd != '0);

endmodule
`default_nettype wire

// File: tb/tb_joy_db15_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_joy_db15_tx : self-checking bench for joy_db15_tx                        |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
module tb_joy_db15_tx;
   localparam int BITS    = 24;
   localparam int SYNC    = 2;
   localparam int TIMEOUT = 100;
   localparam int LAT     = SYNC + 2;

   logic        clk        = 1'b0;
   logic        reset      = 1'b1;
   logic [11:0] joy1       = '0;
   logic [11:0] joy2       = '0;
   logic        joy_load_i = 1'b1;
   logic        joy_clk_i  = 1'b0;
   logic        joy_data_o;
   logic        frame_done;
   logic        active;
   logic [5:0]  bit_cnt;

   int   n_pass  = 0;
   int   n_total = 0;
   int   fd_cnt  = 0;
   logic sb_q[$];

   typedef struct {
      logic [11:0] j1;
      logic [11:0] j2;
      int          pulses;
      logic [5:0]  exp_cnt;
      int          exp_fd;
   } vec_t;

   vec_t vecs[5];

   joy_db15_tx #(.BITS(BITS), .SYNC(SYNC), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .reset      (reset),
      .joy1       (joy1),
      .joy2       (joy2),
      .joy_load_i (joy_load_i),
      .joy_clk_i  (joy_clk_i),
      .joy_data_o (joy_data_o),
      .frame_done (frame_done),
      .active     (active),
      .bit_cnt    (bit_cnt)
   );

   always #5 clk = ~clk;

   // Counted once per cycle, so a pulse wider than one cycle shows up as extra
   always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [11:0] j1, input logic [11:0] j2);
      joy1 = j1;
      joy2 = j2;
      joy_load_i = 1'b0;
      cyc(LAT + 2);
      joy_load_i = 1'b1;
      cyc(LAT + 2);
      joy1 = ~j1;
      joy2 = ~j2;
   endtask

   task automatic pulse(input logic expbit);
      joy_clk_i = 1'b1;
      sb_q.push_back(expbit);
      cyc(LAT + 1);
      check("data_bit", {31'd0, joy_data_o}, {31'd0, sb_q.pop_front()});
      joy_clk_i = 1'b0;
      cyc(LAT + 1);
   endtask

   function automatic logic exp_bit(input logic [23:0] p, input int k);
      return (k < BITS) ? p[BITS-1-k] : 1'b1;
   endfunction

   task automatic run_frame(input vec_t v);
      logic [23:0] p;
      int fd0;
      p = ~{v.j2, v.j1};
      do_load(v.j1, v.j2);
      fd0 = fd_cnt;
      check("first_bit", {31'd0, joy_data_o}, {31'd0, p[BITS-1]});
      check("cnt_after_load", {26'd0, bit_cnt}, 32'd0);
      for (int k = 1; k <= v.pulses; k++) pulse(exp_bit(p, k));
      check("bit_cnt", {26'd0, bit_cnt}, {26'd0, v.exp_cnt});
      check("frame_done_cnt", fd_cnt - fd0, v.exp_fd);
   endtask

   initial begin
      logic [23:0] p;
      int fd0;

      vecs[0] = '{12'h001, 12'h000, 24, 6'd24, 1};
      vecs[1] = '{12'h000, 12'h800, 24, 6'd24, 1};
      vecs[2] = '{12'hA5A, 12'h3C3, 30, 6'd24, 1};
      vecs[3] = '{12'hFFF, 12'hFFF, 10, 6'd10, 0};
      vecs[4] = '{12'h5A5, 12'h0F0, 23, 6'd23, 0};

      cyc(3);
      reset = 1'b0;
      cyc(2);
      check("rst_data", {31'd0, joy_data_o}, 32'd1);
      check("rst_cnt", {26'd0, bit_cnt}, 32'd0);
      check("rst_fd", {31'd0, frame_done}, 32'd0);
      check("rst_active", {31'd0, active}, 32'd0);
      cyc(4);
      check("no_spurious_active", {31'd0, active}, 32'd0);

      // Watchdog: active must fall near TIMEOUT cycles after the load
      joy_load_i = 1'b0;
      cyc(3);
      joy_load_i = 1'b1;
      cyc(TIMEOUT - LAT - 3);
      check("wd_active_hi", {31'd0, active}, 32'd1);
      cyc(2 * LAT);
      check("wd_active_lo", {31'd0, active}, 32'd0);

      // Exact load and shift-clock latencies
      joy1 = 12'h000;
      joy2 = 12'h800;
      joy_load_i = 1'b0;
      cyc(LAT - 1);
      check("load_lat_early", {31'd0, joy_data_o}, 32'd1);
      cyc(1);
      check("load_lat", {31'd0, joy_data_o}, 32'd0);
      cyc(2);
      joy_load_i = 1'b1;
      cyc(LAT + 2);
      joy_clk_i = 1'b1;
      cyc(LAT - 1);
      check("clk_lat_early", {31'd0, joy_data_o}, 32'd0);
      cyc(1);
      check("clk_lat", {31'd0, joy_data_o}, 32'd1);
      joy_clk_i = 1'b0;
      cyc(LAT + 1);
      check("clk_lat_cnt", {26'd0, bit_cnt}, 32'd1);

      for (int i = 0; i < 5; i++) run_frame(vecs[i]);

      // Load coinciding with the final shift edge must win
      fd0 = fd_cnt;
      joy_load_i = 1'b0;
      joy_clk_i  = 1'b1;
      cyc(LAT + 2);
      check("simul_cnt", {26'd0, bit_cnt}, 32'd0);
      joy_load_i = 1'b1;
      joy_clk_i  = 1'b0;
      cyc(LAT + 2);
      check("simul_cnt_after", {26'd0, bit_cnt}, 32'd0);
      check("simul_no_fd", fd_cnt - fd0, 32'd0);

      // Mid-frame reload aborts without frame_done
      fd0 = fd_cnt;
      p = ~{12'h3C3, 12'h123};
      do_load(12'h123, 12'h3C3);
      for (int k = 1; k <= 10; k++) pulse(exp_bit(p, k));
      check("pre_reload_cnt", {26'd0, bit_cnt}, 32'd10);
      run_frame(vecs[2]);
      check("reload_fd_total", fd_cnt - fd0, 32'd1);

      // Asynchronous reset in the middle of a frame
      p = ~{12'h000, 12'h000};
      do_load(12'h000, 12'h000);
      for (int k = 1; k <= 5; k++) pulse(exp_bit(p, k));
      p = ~{12'h0FF, 12'hF00};
      do_load(12'hF00, 12'h0FF);
      for (int k = 1; k <= 3; k++) pulse(exp_bit(p, k));
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_data", {31'd0, joy_data_o}, 32'd1);
      check("async_rst_cnt", {26'd0, bit_cnt}, 32'd0);
      check("async_rst_active", {31'd0, active}, 32'd0);
      cyc(2);
      reset = 1'b0;
      cyc(5);
      check("post_rst_active", {31'd0, active}, 32'd0);
      check("post_rst_cnt", {26'd0, bit_cnt}, 32'd0);
      run_frame(vecs[0]);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
